// File: rtl/reg_file_2r1w_pkg.sv
// Shared defaults and the zero-register address for the 2-read/1-write register file.
package reg_file_2r1w_pkg;

  localparam int unsigned RF_WORD_SIZE_DEF = 32;
  localparam int unsigned RF_ADDR_BITS_DEF = 5;
  localparam int unsigned RF_ZERO_ADDR     = 0;

endpackage

// File: rtl/reg_word_en.sv
// One storage word: a WIDTH-bit register with load enable and async active-high reset.
module reg_word_en #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file with two synchronous read ports, one write port, write-to-read bypass
// and a per-word pending scoreboard for registers reserved by in-flight producers.
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
#(
  parameter int WORD_SIZE = RF_WORD_SIZE_DEF,
  parameter int ADDR_BITS = RF_ADDR_BITS_DEF,
  parameter bit ZERO_REG  = 1'b1,
  parameter bit BYPASS    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic                 re_a,
  input  logic [ADDR_BITS-1:0] raddr_a,
  output logic [WORD_SIZE-1:0] rdata_a,
  output logic                 rpend_a,
  input  logic                 re_b,
  input  logic [ADDR_BITS-1:0] raddr_b,
  output logic [WORD_SIZE-1:0] rdata_b,
  output logic                 rpend_b,
  input  logic                 rsv_en,
  input  logic [ADDR_BITS-1:0] rsv_addr,
  output logic                 pend_any
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [ADDR_BITS-1:0] addr_t;
  typedef struct packed {
    word_t data;
    logic  pend;
  } rd_t;

  localparam addr_t ZADDR = addr_t'(RF_ZERO_ADDR);

  word_t            mem_q [DEPTH];
  logic [DEPTH-1:0] pending;
  logic             w_ok;
  logic             rsv_ok;
  rd_t              rd_a;
  rd_t              rd_b;

  // The hardwired zero word swallows writes and reserves before they reach any state.
  assign w_ok   = we && !(ZERO_REG && (waddr == ZADDR));
  assign rsv_ok = rsv_en && !(ZERO_REG && (rsv_addr == ZADDR));

  // NOTE: storage words are reset like any other flop so reads after reset are defined zeros.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    reg_word_en #(.WIDTH(WORD_SIZE)) u_word (
      .clk (clk),
      .rst (rst),
      .en  (w_ok && (waddr == addr_t'(i))),
      .d   (wdata),
      .q   (mem_q[i])
    );
  end

  // The reserve update follows the write clear, so a new producer overrides a retiring one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (w_ok) pending[waddr] <= 1'b0;
      if (rsv_ok) pending[rsv_addr] <= 1'b1;
    end
  end

  function automatic rd_t read_word(input addr_t ra);
    rd_t rd;
    rd = '{data: mem_q[ra], pend: pending[ra]};
    if (BYPASS && w_ok && (waddr == ra)) rd = '{data: wdata, pend: 1'b0};
    if (ZERO_REG && (ra == ZADDR)) rd = '0;
    return rd;
  endfunction

  // NOTE: each combinational result is fully assigned on every path, so no latch is inferred.
  always_comb begin
    rd_a = read_word(raddr_a);
    rd_b = read_word(raddr_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_a <= '0;
      rpend_a <= 1'b0;
      rdata_b <= '0;
      rpend_b <= 1'b0;
    end else begin
      if (re_a) {rdata_a, rpend_a} <= rd_a;
      if (re_b) {rdata_b, rpend_b} <= rd_b;
    end
  end

  assign pend_any = |pending;

endmodule
